pulse_seq_ctrl: RTL and testbench
=================================

// Module: pulse_seq_ctrl
// PURPOSE
//  Autonomous sequencer that programs the quad pulse core over its MMIO write port.
//  Holds a CPU-loaded table of {target addr, data, dwell}. When started, it issues one
//  single-cycle write per entry, then waits that entry's dwell before the next entry.
//  Supports one-shot or looped playback.
//  Sits between the CPU MMIO slot and quad_pulse_core. The pc_* outputs drive that core directly.
// PARAMETERS
//  DEPTH    16  table entries (power of 2, 2..256)
//  DWELL_W  16  dwell counter width, in clk cycles
// PORTS
//  clk         in   1   system clock
//  reset       in   1   synchronous, active-high
//  cs          in   1   own MMIO slot select
//  wr          in   1   own MMIO write strobe
//  rd          in   1   own MMIO read strobe (no side effects)
//  addr        in   5   own register offset
//  wr_data     in   32  write data
//  rd_data     out  32  read data, combinational from addr
//  pc_cs       out  1   to quad_pulse_core cs
//  pc_wr       out  1   to quad_pulse_core wr
//  pc_addr     out  5   to quad_pulse_core addr ([4:2]=channel, [1:0]=reg)
//  pc_wr_data  out  32  to quad_pulse_core wr_data
//  busy        out  1   sequence running (ISSUE/DWELL)
//  done        out  1   1-cycle pulse when a one-shot sequence completes
// BEHAVIOUR
//  Register map (cs&wr):
//   0 CTRL:  [0] start, [1] stop, [2] loop. Start and stop are self-clearing; loop is stored.
//   1 LEN:   [8:0] entry count; clamped to DEPTH; ignored while busy.
//   2 TIDX:  [7:0] table write pointer (mod DEPTH).
//   3 TCMD:  staging register: [4:0] target addr, [16+DWELL_W-1:16] dwell.
//   4 TDATA: commits {TCMD, wr_data} to table[TIDX]; then TIDX <= TIDX+1 (wraps at DEPTH-1 -> 0).
//  Read map: 0 = {busy[31], loop[30], cur_idx[7:0]}; 1 = LEN; 2 = TIDX; 3 = TCMD; others = 0.
//  Reset: all outputs 0. State IDLE; LEN, TIDX, TCMD, loop and cur_idx = 0; table cleared.
//  FSM states: IDLE, ISSUE, DWELL, DONE.
//   IDLE:  start && LEN!=0 -> ISSUE with cur_idx=0. Start with LEN=0 is ignored.
//   ISSUE: one cycle. pc_cs=pc_wr=1; pc_addr and pc_wr_data come from table[cur_idx].
//          Next state: load dwell counter; DWELL if dwell!=0, otherwise advance.
//   DWELL: counter decrements; at 1 -> advance. ISSUE-to-next-ISSUE spacing = 1+dwell cycles.
//   advance: if cur_idx<LEN-1, cur_idx++ and go to ISSUE.
//            Else if loop: cur_idx=0, ISSUE. Else DONE.
//   DONE:  done=1 for one cycle -> IDLE.
//  pc_* are 0 in every state except ISSUE. busy=1 in ISSUE/DWELL only.
//  Latency: start written at cycle s -> first pc_wr at s+1.
//  stop written at cycle c (any state) -> IDLE at c+1, no done pulse.
//   A pc_wr at cycle c itself still completes. None occurs after c.
//  start and stop in the same write: stop wins. start while busy: ignored.
//  Table/TCMD writes while busy are allowed and take effect when that entry is next issued.
//   A TDATA commit to the current index during ISSUE affects only later issues.
//  loop cleared while running: the current pass finishes, then DONE.
//  reset mid-sequence: immediate return to reset values, including table contents.
// STRUCTURE
//  pulse_seq_pkg: state_t enum; register offset localparams; seq_entry_t struct
//   {addr[4:0], data[31:0], dwell[DWELL_W-1:0]}.
//  Sub-module pulse_seq_table: DEPTH x seq_entry_t register file.
//   One synchronous write port, one asynchronous read port indexed by cur_idx, sync clear.
// TESTING
//  1 Load e0={0x01,0x10,2}, e1={0x05,0x20,0}, e2={0x0A,0x30,5}; LEN=3; start at s
//    -> pc_wr at s+1, s+4, s+5 with the matching addr/data; done at s+11; busy low from s+11.
//  2 LEN=2, loop=1, dwell=1 on each entry; start -> pc_wr every 2 cycles, addr alternating e0/e1.
//    Stop at cycle c -> no pc_wr after c, busy=0 at c+1, done never asserted.
//  3 LEN=0 then start -> stays IDLE, pc_wr never asserted.
//    LEN=40 with DEPTH=16 -> LEN reads back 16.
//  4 Write CTRL=0x3 (start+stop) from IDLE -> no activity.
//    Start while busy -> sequence unchanged, no restart.
//  5 TIDX=15, two TDATA writes -> entries 15 and 0 written; TIDX reads 1.
//  6 Assert reset during DWELL -> next cycle all outputs 0, LEN=0.
//    Start afterwards is ignored until the table and LEN are reloaded.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared types for the pulse sequencer: FSM states, register offsets and
// the table entry layout.
package pulse_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DWELL,
        ST_DONE
    } state_t;

    localparam logic [4:0] REG_CTRL  = 5'd0;
    localparam logic [4:0] REG_LEN   = 5'd1;
    localparam logic [4:0] REG_TIDX  = 5'd2;
    localparam logic [4:0] REG_TCMD  = 5'd3;
    localparam logic [4:0] REG_TDATA = 5'd4;

    // Dwell field is sized for the widest counter TCMD can carry; narrower
    // DWELL_W instances only use the low bits.
    localparam int DWELL_W_MAX = 16;

    typedef struct packed {
        logic [4:0]             addr;
        logic [31:0]            data;
        logic [DWELL_W_MAX-1:0] dwell;
    } seq_entry_t;

endpackage

// File: rtl/pulse_seq_table.sv
// Sequence table: DEPTH entries, one synchronous write port, one asynchronous
// read port, cleared by reset.
module pulse_seq_table
    import pulse_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  seq_entry_t       wentry,
    input  logic [IDX_W-1:0] raddr,
    output seq_entry_t       rentry
);

    seq_entry_t mem_q [DEPTH];

    // Per-entry registers so the whole table can be cleared in one cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_q[gi] <= '0;
                end else if (we && (waddr == IDX_W'(gi))) begin
                    mem_q[gi] <= wentry;
                end
            end
        end
    endgenerate

    assign rentry = mem_q[raddr];

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Table-driven sequencer that plays {addr, data, dwell} entries as single-cycle
// writes into the quad pulse core, one-shot or looped.
module pulse_seq_ctrl
    import pulse_seq_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int DWELL_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr,
    input  logic        rd,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        pc_cs,
    output logic        pc_wr,
    output logic [4:0]  pc_addr,
    output logic [31:0] pc_wr_data,
    output logic        busy,
    output logic        done
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_LEN = 9'(DEPTH);

    state_t               state_q;
    logic [IDX_W-1:0]     cur_idx_q;
    logic [DWELL_W-1:0]   cnt_q;
    logic [8:0]           len_q;
    logic [IDX_W-1:0]     tidx_q;
    logic [4:0]           tcmd_addr_q;
    logic [DWELL_W-1:0]   tcmd_dwell_q;
    logic                 loop_q;

    logic                 reg_wr;
    logic                 start_req;
    logic                 stop_req;
    logic                 tbl_we;
    logic                 issue;
    logic                 last_entry;
    logic [DWELL_W-1:0]   cur_dwell;
    state_t               adv_state_d;
    logic [IDX_W-1:0]     adv_idx_d;
    seq_entry_t           wr_entry;
    seq_entry_t           cur_entry;
    logic                 unused_rd;

    // Reads have no side effects, so the read strobe is not needed.
    assign unused_rd = rd;

    assign reg_wr    = cs && wr;
    assign start_req = reg_wr && (addr == REG_CTRL) && wr_data[0];
    assign stop_req  = reg_wr && (addr == REG_CTRL) && wr_data[1];
    assign tbl_we    = reg_wr && (addr == REG_TDATA);

    assign wr_entry = '{addr: tcmd_addr_q, data: wr_data, dwell: DWELL_W_MAX'(tcmd_dwell_q)};

    pulse_seq_table #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (tbl_we),
        .waddr  (tidx_q),
        .wentry (wr_entry),
        .raddr  (cur_idx_q),
        .rentry (cur_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q        <= '0;
            tidx_q       <= '0;
            tcmd_addr_q  <= '0;
            tcmd_dwell_q <= '0;
            loop_q       <= 1'b0;
        end else if (reg_wr) begin
            case (addr)
                REG_CTRL:  loop_q <= wr_data[2];
                REG_LEN: begin
                    if (!busy) begin
                        len_q <= (wr_data[8:0] > DEPTH_LEN) ? DEPTH_LEN : wr_data[8:0];
                    end
                end
                REG_TIDX:  tidx_q <= wr_data[IDX_W-1:0];
                REG_TCMD: begin
                    tcmd_addr_q  <= wr_data[4:0];
                    tcmd_dwell_q <= wr_data[16 +: DWELL_W];
                end
                REG_TDATA: tidx_q <= tidx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    assign cur_dwell  = cur_entry.dwell[DWELL_W-1:0];
    assign last_entry = (9'(cur_idx_q) + 9'd1) >= len_q;

    always_comb begin
        adv_state_d = ST_DONE;
        adv_idx_d   = cur_idx_q;
        if (!last_entry) begin
            adv_state_d = ST_ISSUE;
            adv_idx_d   = cur_idx_q + IDX_W'(1);
        end else if (loop_q) begin
            adv_state_d = ST_ISSUE;
            adv_idx_d   = '0;
        end
    end

    // Stop overrides everything, including a start in the same write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cur_idx_q <= '0;
            cnt_q     <= '0;
        end else if (stop_req) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_req && (len_q != 9'd0)) begin
                        state_q   <= ST_ISSUE;
                        cur_idx_q <= '0;
                    end
                end
                ST_ISSUE: begin
                    cnt_q <= cur_dwell;
                    if (cur_dwell != '0) begin
                        state_q <= ST_DWELL;
                    end else begin
                        state_q   <= adv_state_d;
                        cur_idx_q <= adv_idx_d;
                    end
                end
                ST_DWELL: begin
                    if (cnt_q == DWELL_W'(1)) begin
                        state_q   <= adv_state_d;
                        cur_idx_q <= adv_idx_d;
                    end else begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign issue      = (state_q == ST_ISSUE);
    assign busy       = issue || (state_q == ST_DWELL);
    assign done       = (state_q == ST_DONE);
    assign pc_cs      = issue;
    assign pc_wr      = issue;
    assign pc_addr    = issue ? cur_entry.addr : 5'd0;
    assign pc_wr_data = issue ? cur_entry.data : 32'd0;

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_CTRL: begin
                rd_data[31]  = busy;
                rd_data[30]  = loop_q;
                rd_data[7:0] = 8'(cur_idx_q);
            end
            REG_LEN:  rd_data[8:0] = len_q;
            REG_TIDX: rd_data[7:0] = 8'(tidx_q);
            REG_TCMD: begin
                rd_data[4:0]          = tcmd_addr_q;
                rd_data[16 +: DWELL_W] = tcmd_dwell_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Scoreboard bench for pulse_seq_ctrl: stimulus queues expected core writes,
// done pulses and reads; a negedge monitor pops and compares them.
module tb_pulse_seq_ctrl;

    localparam int         DEPTH   = 16;
    localparam logic [4:0] A_CTRL  = 5'd0;
    localparam logic [4:0] A_LEN   = 5'd1;
    localparam logic [4:0] A_TIDX  = 5'd2;
    localparam logic [4:0] A_TCMD  = 5'd3;
    localparam logic [4:0] A_TDATA = 5'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic        pc_cs;
    logic        pc_wr;
    logic [4:0]  pc_addr;
    logic [31:0] pc_wr_data;
    logic        busy;
    logic        done;

    pulse_seq_ctrl #(.DEPTH(DEPTH), .DWELL_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .wr         (wr),
        .rd         (rd),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .pc_cs      (pc_cs),
        .pc_wr      (pc_wr),
        .pc_addr    (pc_addr),
        .pc_wr_data (pc_wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: register file and table contents as the CPU sees them.
    int          m_addr  [DEPTH];
    logic [31:0] m_data  [DEPTH];
    int          m_dwell [DEPTH];
    int          m_len, m_tidx, m_cmd_addr, m_cmd_dwell;
    bit          m_loop;
    int          busy_lo = 0;
    int          busy_hi = 0;

    typedef struct {
        int          cyc;
        int          a;
        logic [31:0] d;
    } pc_exp_t;

    pc_exp_t     pcq[$];
    int          doneq[$];
    logic [31:0] rdq[$];

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_addr[i]  = 0;
            m_data[i]  = 32'd0;
            m_dwell[i] = 0;
        end
        m_len = 0; m_tidx = 0; m_cmd_addr = 0; m_cmd_dwell = 0; m_loop = 1'b0;
    endfunction

    function automatic bit model_busy();
        return (cyc >= busy_lo) && (cyc < busy_hi);
    endfunction

    function automatic void model_write(logic [4:0] a, logic [31:0] d);
        case (a)
            A_CTRL: m_loop = d[2];
            A_LEN:  if (!model_busy()) m_len = (int'(d[8:0]) > DEPTH) ? DEPTH : int'(d[8:0]);
            A_TIDX: m_tidx = int'(d[7:0]) % DEPTH;
            A_TCMD: begin m_cmd_addr = int'(d[4:0]); m_cmd_dwell = int'(d[31:16]); end
            A_TDATA: begin
                m_addr[m_tidx]  = m_cmd_addr;
                m_data[m_tidx]  = d;
                m_dwell[m_tidx] = m_cmd_dwell;
                m_tidx = (m_tidx + 1) % DEPTH;
            end
            default: ;
        endcase
    endfunction

    // Expected schedule of a run started at cycle s: each entry occupies
    // 1 + dwell cycles; a stop/reset at stop_c truncates after cycle stop_c.
    function automatic void plan(int s, int stop_c);
        int t = s + 1;
        int i = 0;
        busy_lo = s + 1;
        while (1) begin
            if (stop_c >= 0 && t > stop_c) begin
                busy_hi = stop_c + 1;
                return;
            end
            pcq.push_back('{t, m_addr[i], m_data[i]});
            t += 1 + m_dwell[i];
            i++;
            if (i == m_len) begin
                if (m_loop) i = 0;
                else begin
                    doneq.push_back(t);
                    busy_hi = t;
                    return;
                end
            end
        end
    endfunction

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; wr_data = d;
        model_write(a, d);
    endtask

    task automatic bus_rd(input logic [4:0] a, input logic [31:0] exp);
        @(posedge clk); #1;
        cs = 1'b1; wr = 1'b0; rd = 1'b1; addr = a; wr_data = 32'd0;
        rdq.push_back(exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            cs = 1'b0; wr = 1'b0; rd = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = busy_hi + 2 - cyc;
        idle((n < 1) ? 1 : n);
    endtask

    task automatic load(input int a, input logic [31:0] d, input int dw);
        bus_wr(A_TCMD, {16'(dw), 11'd0, 5'(a)});
        bus_wr(A_TDATA, d);
    endtask

    always @(negedge clk) begin
        pc_exp_t e;
        if (mon_en) begin
            chk("busy", busy, ((cyc >= busy_lo) && (cyc < busy_hi)) ? 1 : 0);
            if (pcq.size() > 0 && pcq[0].cyc < cyc) begin
                e = pcq.pop_front();
                chk("pc_missed", cyc, e.cyc);
            end
            if (pc_wr) begin
                if (pcq.size() == 0) chk("pc_unexpected", 1, 0);
                else begin
                    e = pcq.pop_front();
                    chk("pc_cycle", cyc, e.cyc);
                    chk("pc_addr", pc_addr, e.a);
                    chk("pc_data", pc_wr_data, e.d);
                    chk("pc_cs", pc_cs, 1);
                end
            end else begin
                chk("pc_idle", {pc_cs, pc_addr, pc_wr_data}, 0);
            end
            if (doneq.size() > 0 && doneq[0] < cyc) chk("done_missed", cyc, doneq.pop_front());
            if (done) begin
                if (doneq.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_cycle", cyc, doneq.pop_front());
            end
            if (cs && rd) begin
                if (rdq.size() == 0) chk("rd_unexpected", 1, 0);
                else chk($sformatf("rd_reg%0d", addr), rd_data, rdq.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, c, n;
        bit lp;
        model_clear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        mon_en = 1'b1;

        // Reset values of every register.
        for (int a = 0; a < 6; a++) bus_rd(5'(a), 32'd0);
        bus_rd(5'd31, 32'd0);

        // Directed three-entry one-shot run with hand-derived timing.
        bus_wr(A_TIDX, 32'd0);
        load(8'h01, 32'h10, 2);
        load(8'h05, 32'h20, 0);
        load(8'h0A, 32'h30, 5);
        bus_wr(A_LEN, 32'd3);
        bus_wr(A_CTRL, 32'h1);
        s = cyc;
        pcq.push_back('{s + 1, 5'h01, 32'h10});
        pcq.push_back('{s + 4, 5'h05, 32'h20});
        pcq.push_back('{s + 5, 5'h0A, 32'h30});
        doneq.push_back(s + 11);
        busy_lo = s + 1; busy_hi = s + 11;
        wait_idle();
        bus_rd(A_CTRL, 32'd2);

        // Looped two-entry run, stopped on a cycle that carries a pc_wr.
        bus_wr(A_TIDX, 32'd0);
        load(8'h02, 32'hA, 1);
        load(8'h03, 32'hB, 1);
        bus_wr(A_LEN, 32'd2);
        bus_wr(A_CTRL, 32'h5);
        s = cyc;
        plan(s, s + 9);
        idle(8);
        bus_wr(A_CTRL, 32'h2);
        wait_idle();

        // LEN=0 start is ignored; LEN clamps to DEPTH.
        bus_wr(A_LEN, 32'd0);
        bus_wr(A_CTRL, 32'h1);
        idle(6);
        bus_wr(A_LEN, 32'd40);
        bus_rd(A_LEN, 32'd16);

        // Start+stop together does nothing; start while busy is ignored.
        bus_wr(A_CTRL, 32'h3);
        idle(6);
        bus_wr(A_LEN, 32'd3);
        bus_wr(A_CTRL, 32'h1);
        s = cyc;
        plan(s, -1);
        idle(2);
        bus_wr(A_CTRL, 32'h1);
        wait_idle();

        // Table pointer wraps from 15 to 0; play the full table to see both.
        bus_wr(A_TIDX, 32'd15);
        load(8'h11, 32'hAAAA_0015, 1);
        load(8'h12, 32'h5555_0000, 0);
        bus_rd(A_TIDX, 32'd1);
        bus_wr(A_LEN, 32'd16);
        bus_wr(A_CTRL, 32'h1);
        plan(cyc, -1);
        wait_idle();

        // Randomised table contents, lengths and loop/stop timing.
        for (int it = 0; it < 25; it++) begin
            bus_wr(A_TIDX, 32'($urandom_range(0, 255)));
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) load($urandom_range(0, 31), $urandom(), $urandom_range(0, 3));
            bus_wr(A_LEN, 32'($urandom_range(1, 20)));
            lp = ($urandom_range(0, 2) == 0);
            bus_wr(A_CTRL, {29'd0, lp, 2'b01});
            s = cyc;
            if (lp) begin
                c = s + $urandom_range(1, 40);
                plan(s, c);
                idle(c - s - 1);
                bus_wr(A_CTRL, 32'h2);
                wait_idle();
            end else begin
                plan(s, -1);
                wait_idle();
                bus_rd(A_CTRL, 32'(m_len - 1));
            end
            bus_rd(A_LEN, 32'(m_len));
            bus_rd(A_TIDX, 32'(m_tidx));
            bus_rd(A_TCMD, 32'((m_cmd_dwell << 16) | m_cmd_addr));
            bus_rd(5'($urandom_range(5, 31)), 32'd0);
        end

        // Reset in the middle of a dwell clears everything, table included.
        bus_wr(A_TIDX, 32'd0);
        load(8'h07, 32'h77, 10);
        load(8'h08, 32'h88, 0);
        bus_wr(A_LEN, 32'd2);
        bus_wr(A_CTRL, 32'h1);
        s = cyc;
        plan(s, s + 4);
        idle(3);
        @(posedge clk); #1;
        reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        model_clear();
        @(posedge clk); #1;
        reset = 1'b0;
        bus_rd(A_LEN, 32'd0);
        bus_rd(A_CTRL, 32'd0);
        bus_wr(A_CTRL, 32'h1);
        idle(8);

        chk("pc_queue_left", pcq.size(), 0);
        chk("done_queue_left", doneq.size(), 0);
        chk("rd_queue_left", rdq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
